motor_drive_ctrl: RTL and testbench
===================================

Name: motor_drive_ctrl

Overview:
- Downstream consumer of the ultrasonic path-select code; turns the 2-bit path code into left/right motor PWM and direction signals for the H-bridge.
- Synchronises and debounces the incoming code, then sequences the motors through a ramped brake before any direction change.
- Uses soft-start and soft-stop duty ramps, so no motor ever reverses at non-zero duty.

Parameters:
- PWM_PERIOD, 2500, PWM period in clk cycles (20 kHz at 50 MHz); counter width 12 bits, max 4095.
- DUTY_FWD, 2000, target compare value for both motors in FWD.
- DUTY_TURN, 1500, target compare value for both motors in LEFT/RIGHT.
- RAMP_STEP, 25, maximum duty change per PWM period.
- STABLE_CYC, 1000, consecutive clk cycles a synchronised code must hold before acceptance; valid range 1..65535.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous, active-high reset.
- US, in, 2, path code from the sensor stage: 11 forward, 01 turn right, 10 turn left, 00 obstacle/stop. Asynchronous to clk.
- en, in, 1, drive enable. Low forces a ramp to stop.
- pwm_l, out, 1, left motor PWM.
- pwm_r, out, 1, right motor PWM.
- dir_l, out, 1, left motor direction, 1 = forward.
- dir_r, out, 1, right motor direction, 1 = forward.
- state, out, 3, current FSM state, encoded IDLE=0, FWD=1, RIGHT=2, LEFT=3, BRAKE=4.
- moving, out, 1, high when either applied duty is non-zero.

Behaviour:
- Reset (async, rst=1): pwm_l=pwm_r=0, dir_l=dir_r=1, state=IDLE, moving=0. The PWM counter, both duties, the debounce counter and the accepted code (cmd=00) are all cleared. This holds mid-operation: outputs drop in the same instant rst rises.
- Input path: US passes through a 2-FF synchroniser.
  - A 16-bit stable counter resets to 0 whenever the synchronised value differs from the previous cycle, and otherwise increments, saturating.
  - cmd loads the synchronised value when the counter reaches STABLE_CYC-1.
  - Latency from a US change to a cmd update: 2+STABLE_CYC clk cycles. A glitch shorter than STABLE_CYC never reaches cmd.
- PWM counter: runs 0..PWM_PERIOD-1 and wraps. The period boundary is defined as cnt==PWM_PERIOD-1.
  - pwm_x is registered: 1 when cnt < duty_x. duty=0 gives constant low; duty>=PWM_PERIOD gives constant high.
- Duty ramp: at each period boundary only, duty_x moves toward target_x by at most RAMP_STEP.
  - It never overshoots; when |target-duty| <= RAMP_STEP it lands exactly on target.
  - Both motors always share the same target.
- Requested motion: derived from cmd and en. en=0 means STOP; cmd 11 means FWD; 01 means RIGHT; 10 means LEFT; 00 means STOP.
- FSM transitions:
  - IDLE: targets 0. If the request is a motion, go to that motion state and apply its directions. If STOP, stay.
  - FWD: target DUTY_FWD, dir_l=1, dir_r=1.
  - RIGHT: target DUTY_TURN, dir_l=1, dir_r=0.
  - LEFT: target DUTY_TURN, dir_l=0, dir_r=1.
  - From any motion state, a different request (another motion or STOP) goes to BRAKE. An identical request keeps the state.
  - BRAKE: targets 0, directions held. Once both duties equal 0, go to IDLE. A new motion request arriving during BRAKE is not honoured until IDLE is reached.
- Direction outputs change only on entry into a motion state from IDLE, which guarantees dir changes only at duty=0.
- moving = (duty_l != 0) || (duty_r != 0), registered alongside the duties.
- Simultaneous events:
  - A cmd update on the same cycle as a period boundary: the ramp uses the old target, and the new target applies from the next boundary.
  - en falling on the same cycle as a cmd update: en has priority (STOP).
- Arithmetic: duties are 12 bits unsigned. Ramp-down computes duty-RAMP_STEP with no underflow, clamping at target. Ramp-up clamps at target.

Test Plan (sim parameters: PWM_PERIOD=100, DUTY_FWD=80, DUTY_TURN=60, RAMP_STEP=20, STABLE_CYC=4):
- Reset then US=11, en=1 -> cmd=11 after 6 clk; state=FWD; duty steps 20,40,60,80 at successive boundaries; pwm_l high 80 of every 100 cycles thereafter; dir_l=dir_r=1; moving=1.
- FWD steady, US pulses 01 for 3 clk then back to 11 -> cmd unchanged, state stays FWD, duty stays 80.
- FWD at duty 80, US=01 held -> BRAKE; duty 60,40,20,0 over 4 boundaries; IDLE; then RIGHT with dir_r=0, set only while duty=0; duty ramps to 60.
- RIGHT at duty 60, en=0 -> BRAKE; ramp to 0; IDLE; moving=0; pwm outputs constantly low; dir held.
- Assert rst mid-ramp in FWD at duty 40 -> outputs low and state=IDLE asynchronously; after release with US=11, the ramp restarts from 20.
- BRAKE in progress, US changes 01->10 -> no direction change until duty=0 and IDLE; then LEFT with dir_l=0, dir_r=1.

Source files
------------

// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: turns a debounced 2-bit path code into ramped left/right motor PWM and direction.
// Ports: clk, rst (async, active high); US path code (11 fwd, 01 right, 10 left, 00 stop), en drive enable;
//        pwm_l/pwm_r motor PWM, dir_l/dir_r direction (1 = forward), state FSM state, moving duty non-zero.
module motor_drive_ctrl #(
    parameter int PWM_PERIOD = 2500,
    parameter int DUTY_FWD   = 2000,
    parameter int DUTY_TURN  = 1500,
    parameter int RAMP_STEP  = 25,
    parameter int STABLE_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] US,
    input  logic       en,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic [2:0] state,
    output logic       moving
);
    localparam logic [2:0] IDLE = 3'd0, FWD = 3'd1, RIGHT = 3'd2, LEFT = 3'd3, BRAKE = 3'd4;
    localparam logic [11:0] P_LAST = 12'(PWM_PERIOD - 1);
    localparam logic [11:0] D_FWD  = 12'(DUTY_FWD);
    localparam logic [11:0] D_TURN = 12'(DUTY_TURN);
    localparam logic [11:0] STEP   = 12'(RAMP_STEP);
    localparam logic [15:0] S_LAST = 16'(STABLE_CYC - 1);

    logic [1:0]  us_s1, us_s2, us_prev, cmd;
    logic [15:0] stab, stab_nxt;
    logic [11:0] cnt, duty_l, duty_r, dl_nxt, dr_nxt, target;
    logic [2:0]  req, nxt;
    logic        bdry;

    // One ramp step toward t; lands exactly on t when within one step, so it never overshoots.
    function automatic logic [11:0] ramp(input logic [11:0] d, input logic [11:0] t);
        ramp = (d < t) ? ((t - d <= STEP) ? t : d + STEP)
                       : ((d - t <= STEP) ? t : d - STEP);
    endfunction

    always_comb begin
        stab_nxt = (us_s2 != us_prev) ? '0 : (stab == 16'hffff) ? stab : stab + 16'd1;
        bdry     = cnt == P_LAST;
        dl_nxt   = bdry ? ramp(duty_l, target) : duty_l;
        dr_nxt   = bdry ? ramp(duty_r, target) : duty_r;
        req      = !en ? IDLE : cmd == 2'b11 ? FWD : cmd == 2'b01 ? RIGHT : cmd == 2'b10 ? LEFT : IDLE;
    end

    // Synchroniser and debounce: cmd only follows a code that held for STABLE_CYC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_s1   <= '0;
            us_s2   <= '0;
            us_prev <= '0;
            stab    <= '0;
            cmd     <= '0;
        end else begin
            us_s1   <= US;
            us_s2   <= us_s1;
            us_prev <= us_s2;
            stab    <= stab_nxt;
            if (stab_nxt == S_LAST) cmd <= us_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            duty_l <= '0;
            duty_r <= '0;
            pwm_l  <= 1'b0;
            pwm_r  <= 1'b0;
            moving <= 1'b0;
        end else begin
            cnt    <= bdry ? '0 : cnt + 12'd1;
            duty_l <= dl_nxt;
            duty_r <= dr_nxt;
            pwm_l  <= cnt < duty_l;
            pwm_r  <= cnt < duty_r;
            moving <= (dl_nxt != '0) || (dr_nxt != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:             nxt = req;
            FWD, RIGHT, LEFT: nxt = (req != state) ? BRAKE : state;
            BRAKE:            nxt = (duty_l == '0 && duty_r == '0) ? IDLE : BRAKE;
            default:          nxt = IDLE;
        endcase
    end

    always_comb begin
        target = state == FWD ? D_FWD : (state == RIGHT || state == LEFT) ? D_TURN : '0;
    end

    // Directions only change when leaving IDLE, where both duties are zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_l <= 1'b1;
            dir_r <= 1'b1;
        end else if (state == IDLE && nxt != IDLE) begin
            dir_l <= nxt != LEFT;
            dir_r <= nxt != RIGHT;
        end
    end
endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb_motor_drive_ctrl: scoreboard bench driving directed and random path codes against a behavioural model.
module tb_motor_drive_ctrl;
    localparam int P = 100, DF = 80, DT = 60, RS = 20, SC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] US  = 2'b00;
    logic       en  = 1'b0;
    logic       pwm_l, pwm_r, dir_l, dir_r, moving;
    logic [2:0] state;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] expq[$];

    motor_drive_ctrl #(
        .PWM_PERIOD(P), .DUTY_FWD(DF), .DUTY_TURN(DT), .RAMP_STEP(RS), .STABLE_CYC(SC)
    ) dut (
        .clk(clk), .rst(rst), .US(US), .en(en),
        .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
        .state(state), .moving(moving)
    );

    always #5 clk = ~clk;

    // Reference model: evaluated once per rising edge, expected outputs queued for the monitor.
    initial begin : model
        int m_cnt, m_duty, m_st, m_cmd, tgt, req, nst, d;
        bit m_pwm, m_mov, m_dl, m_dr, same;
        bit [1:0] hist[$];
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt = 0; m_duty = 0; m_st = 0; m_cmd = 0;
                m_pwm = 0; m_mov = 0; m_dl = 1; m_dr = 1;
                hist.delete();
                for (int i = 0; i < SC + 2; i++) hist.push_back(2'b00);
            end else begin
                tgt = (m_st == 1) ? DF : (m_st == 2 || m_st == 3) ? DT : 0;
                req = !en ? 0 : m_cmd == 3 ? 1 : m_cmd == 1 ? 2 : m_cmd == 2 ? 3 : 0;
                if (m_st == 0)      nst = req;
                else if (m_st == 4) nst = (m_duty == 0) ? 0 : 4;
                else                nst = (req == m_st) ? m_st : 4;
                if (m_st == 0 && nst != 0) begin
                    m_dl = (nst != 3);
                    m_dr = (nst != 2);
                end
                m_pwm = m_cnt < m_duty;
                if (m_cnt == P - 1) begin
                    d = tgt - m_duty;
                    if (d > RS)  d = RS;
                    if (d < -RS) d = -RS;
                    m_duty = m_duty + d;
                    m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
                m_mov = m_duty != 0;
                m_st = nst;
                // cmd follows a synchronised code (two samples late) once SC consecutive samples agree
                hist.push_back(US);
                while (hist.size() > SC + 2) void'(hist.pop_front());
                same = 1;
                for (int i = 1; i < SC; i++) if (hist[i] != hist[0]) same = 0;
                if (same) m_cmd = int'(hist[0]);
            end
            expq.push_back({m_pwm, m_pwm, m_dl, m_dr, 3'(m_st), m_mov});
        end
    end

    initial begin : monitor
        logic [7:0] exp_v, got;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                exp_v = expq.pop_front();
                got = {pwm_l, pwm_r, dir_l, dir_r, state, moving};
                total++;
                if (got !== exp_v) begin
                    bad++;
                    $display("FAIL outputs t=%0t pwm_l,pwm_r,dir_l,dir_r,state,moving got=%b required=%b",
                             $time, got, exp_v);
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req_v);
        total++;
        if (got !== req_v) begin
            bad++;
            $display("FAIL %s got=%b required=%b", name, got, req_v);
        end
    endtask

    initial begin : stim
        int n;
        hold(3);
        rst = 1'b0; US = 2'b11; en = 1'b1;
        hold(600);
        US = 2'b01; hold(3);
        US = 2'b11; hold(200);
        US = 2'b01; hold(1200);
        en = 1'b0; hold(700);
        en = 1'b1; US = 2'b11; hold(260);
        #1 rst = 1'b1;
        #1 chk("async_reset", {pwm_l, pwm_r, dir_l, dir_r, state, moving}, 8'b0011_0000);
        hold(2);
        rst = 1'b0;
        hold(500);
        US = 2'b01; hold(150);
        US = 2'b10; hold(1200);
        for (int k = 0; k < 40; k++) begin
            US = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 7) != 0);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(50, 700);
            hold(n);
        end
        hold(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
